// File: rtl/mul_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mul_product_accumulator
// Summary  : Sums a valid/ready stream of signed 16-bit products into a signed
//            ACC_W accumulator. The result is presented on a registered
//            handshake after the beat flagged last is accepted.
//            Optional macro MUL_ACC_SAT_EN selects a saturating accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mul_product_accumulator #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_count;
   logic               r_ovf;
   logic               r_out_valid;
   logic [ACC_W-1:0]   r_out_acc;
   logic [CNT_W-1:0]   r_out_count;
   logic               r_out_ovf;

   logic [ACC_W-1:0]   w_prod_ext;
   logic [ACC_W-1:0]   w_sum;
   logic               w_pos_ovf;
   logic               w_neg_ovf;
   logic [ACC_W-1:0]   w_acc_next;
   logic [CNT_W-1:0]   w_count_next;
   logic               w_ovf_next;
   logic               w_accept;

   assign in_ready = (r_state == ST_ACCUM) && !clear;
   assign w_accept = in_valid && in_ready;

   // Overflow only when both operands share a sign and the result flips it.
   always_comb begin
      w_prod_ext = {{(ACC_W-16){in_product[15]}}, in_product};
      w_sum      = r_acc + w_prod_ext;
      w_pos_ovf  = ~r_acc[ACC_W-1] & ~w_prod_ext[ACC_W-1] &  w_sum[ACC_W-1];
      w_neg_ovf  =  r_acc[ACC_W-1] &  w_prod_ext[ACC_W-1] & ~w_sum[ACC_W-1];
      w_ovf_next = r_ovf | w_pos_ovf | w_neg_ovf;
`ifdef MUL_ACC_SAT_EN
      if (w_pos_ovf) begin
         w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
      end else if (w_neg_ovf) begin
         w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
         w_acc_next = w_sum;
      end
`else
      w_acc_next = w_sum;
`endif
      if (&r_count) begin
         w_count_next = r_count;
      end else begin
         w_count_next = r_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ACCUM;
         r_acc       <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_acc   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else if (clear) begin
         r_state     <= ST_ACCUM;
         r_acc       <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_accept) begin
                  r_acc   <= w_acc_next;
                  r_count <= w_count_next;
                  r_ovf   <= w_ovf_next;
                  if (in_last) begin
                     r_out_acc   <= w_acc_next;
                     r_out_count <= w_count_next;
                     r_out_ovf   <= w_ovf_next;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_acc       <= '0;
                  r_count     <= '0;
                  r_ovf       <= 1'b0;
                  r_state     <= ST_ACCUM;
               end
            end
            default: begin
               r_state <= ST_ACCUM;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_acc   = r_out_acc;
   assign out_count = r_out_count;
   assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mul_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_product_accumulator
// Summary  : Scoreboard bench driving three parameterisations of
//            mul_product_accumulator with the same directed beat stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_product_accumulator;

   typedef struct {
      int acc;
      int cnt;
      int ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   logic clear;
   logic in_valid;
   logic [15:0] in_product;
   logic in_last;
   logic out_ready;

   logic rdy_a, rdy_b, rdy_c;
   logic va, vb, vc;
   logic signed [23:0] acc_a;
   logic signed [16:0] acc_b;
   logic signed [23:0] acc_c;
   logic [7:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;
   logic ovf_a, ovf_b, ovf_c;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   exp_t ea, eb, ec;

   int errors = 0;
   int checks = 0;

   mul_product_accumulator #(.ACC_W(24), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
      .in_product(in_product), .in_last(in_last), .out_valid(va), .out_ready(out_ready),
      .out_acc(acc_a), .out_count(cnt_a), .out_ovf(ovf_a));

   mul_product_accumulator #(.ACC_W(17), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
      .in_product(in_product), .in_last(in_last), .out_valid(vb), .out_ready(out_ready),
      .out_acc(acc_b), .out_count(cnt_b), .out_ovf(ovf_b));

   mul_product_accumulator #(.ACC_W(24), .CNT_W(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_c),
      .in_product(in_product), .in_last(in_last), .out_valid(vc), .out_ready(out_ready),
      .out_acc(acc_c), .out_count(cnt_c), .out_ovf(ovf_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input int a, input int c, input int o);
      exp_t e;
      e.acc = a;
      e.cnt = c;
      e.ovf = o;
      return e;
   endfunction

   task automatic push_all(input exp_t e_a, input exp_t e_b, input exp_t e_c);
      qa.push_back(e_a);
      qb.push_back(e_b);
      qc.push_back(e_c);
   endtask

   // Holds the beat until accepted; returns 1 time unit after the accepting edge.
   task automatic send(input int p, input bit last);
      int n;
      n = 0;
      in_valid   = 1'b1;
      in_product = 16'(p);
      in_last    = last;
      @(negedge clk);
      while (!rdy_a && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!rdy_a) begin
         chk("send_timeout", 0, 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && va && out_ready) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_output", 1, 0);
         end else begin
            ea = qa.pop_front();
            chk("a_acc", acc_a, ea.acc);
            chk("a_count", cnt_a, ea.cnt);
            chk("a_ovf", ovf_a, ea.ovf);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && vb && out_ready) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_output", 1, 0);
         end else begin
            eb = qb.pop_front();
            chk("b_acc", acc_b, eb.acc);
            chk("b_count", cnt_b, eb.cnt);
            chk("b_ovf", ovf_b, eb.ovf);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && vc && out_ready) begin
         if (qc.size() == 0) begin
            chk("c_unexpected_output", 1, 0);
         end else begin
            ec = qc.pop_front();
            chk("c_acc", acc_c, ec.acc);
            chk("c_count", cnt_c, ec.cnt);
            chk("c_ovf", ovf_c, ec.ovf);
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      clear      = 1'b0;
      in_valid   = 1'b0;
      in_product = '0;
      in_last    = 1'b0;
      out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      chk("reset_in_ready", rdy_a, 1);
      chk("reset_out_valid", va, 0);
      chk("reset_out_acc", acc_a, 0);
      chk("reset_out_count", cnt_a, 0);
      chk("reset_out_ovf", ovf_a, 0);

      // Basic dot product: 100 - 30 + 7
      out_ready = 1'b1;
      push_all(mk(77, 3, 0), mk(77, 3, 0), mk(77, 3, 0));
      send(100, 0);
      send(-30, 0);
      send(7, 1);
      chk("basic_valid_rise", va, 1);
      chk("basic_hold_ready", rdy_a, 0);
      @(posedge clk);
      #1;
      chk("basic_valid_one_cycle", va, 0);
      chk("basic_ready_back", rdy_a, 1);

      // Backpressure on a single-beat sum
      out_ready = 1'b0;
      push_all(mk(-16384, 1, 0), mk(-16384, 1, 0), mk(-16384, 1, 0));
      send(-16384, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid_held", va, 1);
         chk("bp_acc_held", acc_a, -16384);
         chk("bp_ready_low", rdy_a, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_released", va, 0);

      // Overflow only in the 17-bit accumulator
`ifdef MUL_ACC_SAT_EN
      push_all(mk(98301, 3, 0), mk(65535, 3, 1), mk(98301, 3, 0));
`else
      push_all(mk(98301, 3, 0), mk(-32771, 3, 1), mk(98301, 3, 0));
`endif
      send(32767, 0);
      send(32767, 0);
      send(32767, 1);

      // Clear mid-sum; 70 is offered with clear and must be refused
      push_all(mk(5, 1, 0), mk(5, 1, 0), mk(5, 1, 0));
      send(50, 0);
      send(60, 0);
      in_valid   = 1'b1;
      in_product = 16'(70);
      clear      = 1'b1;
      #1;
      chk("clear_blocks_ready", rdy_a, 0);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      send(5, 1);

      // Zero product still counts as a term
      push_all(mk(-1, 2, 0), mk(-1, 2, 0), mk(-1, 2, 0));
      send(0, 0);
      send(-1, 1);

      // Counter saturation in the 2-bit counter instance
      push_all(mk(5, 5, 0), mk(5, 5, 0), mk(5, 3, 0));
      for (int i = 0; i < 5; i++) begin
         send(1, (i == 4));
      end
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset while holding a result
      out_ready = 1'b0;
      send(1234, 1);
      chk("hold_before_reset", va, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", va, 0);
      chk("async_rst_acc", acc_a, 0);
      chk("async_rst_count", cnt_a, 0);
      chk("async_rst_ovf", ovf_a, 0);
      chk("async_rst_ready", rdy_a, 1);
      chk("async_rst_valid_b", vb, 0);
      chk("async_rst_acc_b", acc_b, 0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("no_output_after_reset", va, 0);

      chk("queue_a_drained", qa.size(), 0);
      chk("queue_b_drained", qb.size(), 0);
      chk("queue_c_drained", qc.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
